// File: rtl/aes_pkg.sv
// Shared AES SubBytes definitions: forward/inverse S-box tables and FSM states.
// The inverse table exists only when SUB_BYTES_INV_EN is defined.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sb_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef SUB_BYTES_INV_EN
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
`endif

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lane; inv selects the inverse table.
// Inverse table only present when SUB_BYTES_INV_EN is defined.
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic       inv,
  input  logic [7:0] data,
  output logic [7:0] sub
);

`ifdef SUB_BYTES_INV_EN
  assign sub = inv ? INV_SBOX[data] : SBOX[data];
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign sub = SBOX[data];
`endif

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: LANES shared S-boxes over NUM_BYTES/LANES beats.
// Define SUB_BYTES_INV_EN to enable per-block InvSubBytes via in_inv.
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int DATA_LEN = 128,
  parameter int LANES    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_LEN-1:0] in_data,
  input  logic                in_inv,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] out_data,
  output logic                busy
);

  localparam int NUM_BYTES = DATA_LEN / 8;
  localparam int BEATS     = NUM_BYTES / LANES;
  localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

  if ((DATA_LEN % 8) != 0 || (NUM_BYTES % LANES) != 0) begin : g_bad_cfg
    $error("sub_bytes_iter: LANES must divide DATA_LEN/8");
  end

  sb_state_t                state;
  logic [CNT_W-1:0]         cnt;
  logic [DATA_LEN-1:0]      blk;
  logic                     mode;
  logic [LANES-1:0][7:0]    lane_in;
  logic [LANES-1:0][7:0]    lane_out;

  assign in_ready = (state == IDLE) & ~reset;
  assign out_data = blk;

  // Lane j always sees byte cnt*LANES+j of the working state.
  always_comb begin
    lane_in = '0;
    for (int j = 0; j < LANES; j++) begin
      lane_in[j] = blk[(int'(cnt) * LANES + j) * 8 +: 8];
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    aes_sbox_lane u_lane (
      .inv  (mode),
      .data (lane_in[j]),
      .sub  (lane_out[j])
    );
  end

`ifndef SUB_BYTES_INV_EN
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
  assign mode = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      blk       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SUB_BYTES_INV_EN
      mode      <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            blk   <= in_data;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef SUB_BYTES_INV_EN
            mode  <= in_inv;
`endif
          end
        end
        RUN: begin
          for (int j = 0; j < LANES; j++) begin
            blk[(int'(cnt) * LANES + j) * 8 +: 8] <= lane_out[j];
          end
          if (cnt == CNT_W'(BEATS - 1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Self-checking bench for sub_bytes_iter against a GF(2^8) S-box model.
// Honours SUB_BYTES_INV_EN to select inverse-mode expectations.
module tb_sub_bytes_iter;

  localparam int DATA_LEN = 128;
  localparam int LANES    = 4;
  localparam int NB       = DATA_LEN / 8;
  localparam int BEATS    = NB / LANES;
`ifdef SUB_BYTES_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_LEN-1:0] in_data;
  logic                in_inv;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_LEN-1:0] out_data;
  logic                busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  typedef struct {
    logic [DATA_LEN-1:0] data;
    logic                inv;
    logic [DATA_LEN-1:0] exp;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;

  sub_bytes_iter #(.DATA_LEN(DATA_LEN), .LANES(LANES)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_inv    (in_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254, then the AES affine map.
  function automatic logic [7:0] model_sbox(logic [7:0] x);
    logic [7:0] v, r, s;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gmul(v, x);
    r = v;
    s = v;
    for (int k = 0; k < 4; k++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [DATA_LEN-1:0] model_block(logic [DATA_LEN-1:0] d,
                                                      logic inv);
    logic [DATA_LEN-1:0] o;
    o = '0;
    for (int i = 0; i < NB; i++) begin
      o[8*i +: 8] = (INV_EN && inv) ? inv_t[d[8*i +: 8]] : fwd_t[d[8*i +: 8]];
    end
    return o;
  endfunction

  function automatic logic [DATA_LEN-1:0] rand_block();
    logic [DATA_LEN-1:0] d;
    for (int i = 0; i < DATA_LEN / 32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  task automatic check(input string name, input logic [DATA_LEN-1:0] act,
                       input logic [DATA_LEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_block(input logic [DATA_LEN-1:0] d, input logic inv,
                           output logic [DATA_LEN-1:0] res, output int lat);
    int k;
    k = 0;
    while (!in_ready && k < 100) begin tick(); k++; end
    check("in_ready_wait", in_ready, 1);
    in_data  = d;
    in_inv   = inv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    res = out_data;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [DATA_LEN-1:0] res, held, acc_d;
    int lat, k, cyc;
    int acc_cyc[$];
    logic [DATA_LEN-1:0] exp_q[$];

    for (int x = 0; x < 256; x++) fwd_t[x] = model_sbox(8'(x));
    for (int x = 0; x < 256; x++) inv_t[fwd_t[x]] = 8'(x);

    vecs[0] = '{128'h00112233445566778899aabbccddeeff, 1'b0,
                128'h638293c31bfc33f5c4eeacea4bc12816};
    vecs[1] = '{'0, 1'b0, {16{8'h63}}};
    vecs[2] = '{{16{8'hff}}, 1'b0, {16{8'h16}}};
    vecs[3] = '{{16{8'h01}}, 1'b0, {16{8'h7c}}};
`ifdef SUB_BYTES_INV_EN
    vecs[4] = '{128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1,
                128'h00112233445566778899aabbccddeeff};
`else
    vecs[4] = '{'0, 1'b1, {16{8'h63}}};
`endif

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    tick();
    check("idle_in_ready", in_ready, 1);

    for (int v = 0; v < 5; v++) begin
      run_block(vecs[v].data, vecs[v].inv, res, lat);
      check($sformatf("vec%0d_data", v), res, vecs[v].exp);
      check($sformatf("vec%0d_latency", v), lat, BEATS);
    end

    for (int r = 0; r < 8; r++) begin
      acc_d = rand_block();
      k = int'($urandom_range(0, 1));
      run_block(acc_d, k[0], res, lat);
      check($sformatf("rand%0d_data", r), res, model_block(acc_d, k[0]));
    end

    // Back-pressure: DONE must hold and ignore new input.
    acc_d = rand_block();
    in_data = acc_d; in_inv = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin tick(); k++; end
    held = out_data;
    check("bp_data", held, model_block(acc_d, 1'b0));
    in_valid = 1'b1; in_data = ~acc_d;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, held);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);

    // Reset mid-RUN after two beats.
    in_data = rand_block(); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("mid_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_out_data", out_data, 0);
    check("abort_in_ready", in_ready, 0);
    tick();
    reset = 1'b0;
    run_block({16{8'hff}}, 1'b0, res, lat);
    check("after_abort_data", res, {16{8'h16}});
    check("after_abort_latency", lat, BEATS);

    // Streaming with inputs scrambled every cycle.
    in_valid = 1'b1; out_ready = 1'b1;
    in_data = rand_block(); in_inv = 1'($urandom);
    for (cyc = 0; cyc < (BEATS + 2) * 4 + 2; cyc++) begin
      if (out_valid) begin
        if (exp_q.size() > 0) check("stream_data", out_data, exp_q.pop_front());
        else check("stream_spurious", out_valid, 0);
      end
      if (in_ready) begin
        acc_cyc.push_back(cyc);
        exp_q.push_back(model_block(in_data, in_inv));
      end
      tick();
      in_data = rand_block(); in_inv = 1'($urandom);
    end
    in_valid = 1'b0;
    check("stream_accepts", acc_cyc.size() >= 3, 1);
    for (int i = 1; i < acc_cyc.size(); i++) begin
      check("stream_spacing", acc_cyc[i] - acc_cyc[i-1], BEATS + 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
